// File: rtl/fifo_prog_pkg.sv
// Shared helpers for the programmable-threshold FIFO.
// Elaboration-time parameter checks live here so every user applies the same rules.
package fifo_prog_pkg;

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// Register array behind fifo_prog: one write port, combinational read port.
// Every entry clears on reset so the head reads 0 straight out of reset.
module fifo_regfile #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mem[gi] <= '0;
        end else if (we && (waddr == AW'(gi))) begin
          mem[gi] <= wdata;
        end
      end
    end
  endgenerate

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_prog.sv
// Show-ahead synchronous FIFO with programmable thresholds, flush and sticky error flags.
// Define FIFO_WATERMARK_EN to add the max_level peak-occupancy output.
module fifo_prog
  import fifo_prog_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_THRESH  = FIFO_DEPTH - 1,
  parameter int AE_THRESH  = 1,
  localparam int FW        = $clog2(FIFO_DEPTH + 1),
  localparam int AW        = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] read_data,
  input  logic                  flush,
  input  logic                  err_clr,
  output logic [FW-1:0]         fill_level,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
`ifdef FIFO_WATERMARK_EN
  ,
  output logic [FW-1:0]         max_level
`endif
);

  localparam bit CFG_OK = is_pow2(FIFO_DEPTH) && (FIFO_DEPTH >= 2) && (DATA_WIDTH >= 1)
                          && (AF_THRESH >= 1) && (AF_THRESH <= FIFO_DEPTH)
                          && (AE_THRESH >= 0) && (AE_THRESH <= FIFO_DEPTH - 1);

  always_ff @(posedge clk) begin
    assert (CFG_OK) else $error("fifo_prog: illegal depth or threshold parameters");
  end

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr_next;
  logic [AW-1:0] rd_ptr_next;
  logic [FW-1:0] fill_next;
  logic          wr_cmd;
  logic          rd_cmd;
  logic          ov_set;
  logic          uf_set;

  assign full         = (fill_level == FW'(FIFO_DEPTH));
  assign empty        = (fill_level == '0);
  assign almost_full  = (fill_level >= FW'(AF_THRESH));
  assign almost_empty = (fill_level <= FW'(AE_THRESH));

  // Flush masks both commands, so it also suppresses the error flags.
  assign wr_cmd = write & ~full  & ~flush;
  assign rd_cmd = read  & ~empty & ~flush;
  assign ov_set = write & full  & ~flush;
  assign uf_set = read  & empty & ~flush;

  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    fill_next   = fill_level;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      fill_next   = '0;
    end else begin
      if (wr_cmd) wr_ptr_next = wr_ptr + AW'(1);
      if (rd_cmd) rd_ptr_next = rd_ptr + AW'(1);
      fill_next = fill_level + FW'(wr_cmd) - FW'(rd_cmd);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_next;
      rd_ptr     <= rd_ptr_next;
      fill_level <= fill_next;
      // A new error in the same cycle as err_clr keeps the flag set.
      if (ov_set)       overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
      if (uf_set)       underflow <= 1'b1;
      else if (err_clr) underflow <= 1'b0;
    end
  end

`ifdef FIFO_WATERMARK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_level <= '0;
    end else if (fill_next > max_level) begin
      max_level <= fill_next;
    end else if (err_clr) begin
      max_level <= '0;
    end
  end
`endif

  fifo_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_cmd),
    .waddr (wr_ptr),
    .wdata (write_data),
    .raddr (rd_ptr),
    .rdata (read_data)
  );

endmodule

// File: tb/tb_fifo_prog.sv
// Directed self-checking bench for fifo_prog at depth 4, AF=3, AE=1.
// Build with FIFO_WATERMARK_EN defined to also exercise max_level.
module tb_fifo_prog;

  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int FW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          write = 1'b0;
  logic [DW-1:0] write_data = '0;
  logic          read = 1'b0;
  logic [DW-1:0] read_data;
  logic          flush = 1'b0;
  logic          err_clr = 1'b0;
  logic [FW-1:0] fill_level;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
`ifdef FIFO_WATERMARK_EN
  logic [FW-1:0] max_level;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_prog #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .AF_THRESH  (3),
    .AE_THRESH  (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .write        (write),
    .write_data   (write_data),
    .read         (read),
    .read_data    (read_data),
    .flush        (flush),
    .err_clr      (err_clr),
    .fill_level   (fill_level),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
`ifdef FIFO_WATERMARK_EN
    ,
    .max_level    (max_level)
`endif
  );

  // One clock edge with the currently driven inputs; outputs settle 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
    $display("txn: wr=%0b wd=%02h rd=%0b fl=%0b ec=%0b -> fill=%0d rdata=%02h ov=%0b uf=%0b",
             write, write_data, read, flush, err_clr, fill_level, read_data, overflow, underflow);
  endtask

  task automatic idle();
    write = 1'b0; read = 1'b0; flush = 1'b0; err_clr = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++;
    if (fill_level !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || almost_empty !== 1'b1 ||
        almost_full !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0 || read_data !== 8'h00) begin
      errors++;
      $display("FAIL reset: fill=%0d empty=%0b full=%0b ae=%0b af=%0b ov=%0b uf=%0b rdata=%02h, required 0 1 0 1 0 0 0 00",
               fill_level, empty, full, almost_empty, almost_full, overflow, underflow, read_data);
    end
`ifdef FIFO_WATERMARK_EN
    checks++;
    if (max_level !== 3'd0) begin
      errors++;
      $display("FAIL reset_max: max_level=%0d required 0", max_level);
    end
`endif
    rst = 1'b0;
    step();
  endtask

  task automatic test_fill();
    logic [DW-1:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic          exp_ae [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic          exp_af [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic          exp_fu [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      write = 1'b1; write_data = vals[i];
      step();
      checks++;
      if (fill_level !== FW'(i + 1) || almost_empty !== exp_ae[i] || almost_full !== exp_af[i] ||
          full !== exp_fu[i] || empty !== 1'b0 || read_data !== 8'h11) begin
        errors++;
        $display("FAIL fill[%0d]: fill=%0d ae=%0b af=%0b full=%0b empty=%0b rdata=%02h, required %0d %0b %0b %0b 0 11",
                 i, fill_level, almost_empty, almost_full, full, empty, read_data,
                 i + 1, exp_ae[i], exp_af[i], exp_fu[i]);
      end
    end
    idle();
  endtask

  task automatic test_overflow();
    logic [DW-1:0] rest [3] = '{8'h22, 8'h33, 8'h44};
    write = 1'b1; write_data = 8'h55; read = 1'b1;
    step();
    idle();
    checks++;
    if (fill_level !== 3'd3 || overflow !== 1'b1 || full !== 1'b0 || read_data !== 8'h22 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow: fill=%0d ov=%0b full=%0b rdata=%02h uf=%0b, required 3 1 0 22 0",
               fill_level, overflow, full, read_data, underflow);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (read_data !== rest[i]) begin
        errors++;
        $display("FAIL drain[%0d]: rdata=%02h required %02h", i, read_data, rest[i]);
      end
      read = 1'b1;
      step();
    end
    idle();
    checks++;
    if (empty !== 1'b1 || fill_level !== 3'd0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL drained: empty=%0b fill=%0d ov=%0b, required 1 0 1", empty, fill_level, overflow);
    end
  endtask

  task automatic test_underflow();
    read = 1'b1; write = 1'b1; write_data = 8'hA0;
    step();
    idle();
    checks++;
    if (fill_level !== 3'd1 || underflow !== 1'b1 || read_data !== 8'hA0) begin
      errors++;
      $display("FAIL underflow: fill=%0d uf=%0b rdata=%02h, required 1 1 a0", fill_level, underflow, read_data);
    end
    err_clr = 1'b1;
    step();
    idle();
    checks++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL err_clr: ov=%0b uf=%0b, required 0 0", overflow, underflow);
    end
    read = 1'b1;
    step();
    // Read on empty together with err_clr: the new underflow must win.
    read = 1'b1; err_clr = 1'b1;
    step();
    idle();
    checks++;
    if (underflow !== 1'b1 || overflow !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL set_wins: uf=%0b ov=%0b empty=%0b, required 1 0 1", underflow, overflow, empty);
    end
    err_clr = 1'b1;
    step();
    idle();
  endtask

  task automatic test_wrap();
    // Advance both pointers to 3 before the paired traffic.
    for (int i = 0; i < 2; i++) begin write = 1'b1; write_data = 8'hEE; step(); end
    idle();
    for (int i = 0; i < 2; i++) begin read = 1'b1; step(); end
    idle();
    write = 1'b1; write_data = 8'h00;
    step();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (read_data !== DW'(i) || fill_level !== 3'd1) begin
        errors++;
        $display("FAIL wrap[%0d]: rdata=%02h fill=%0d, required %02h 1", i, read_data, fill_level, i);
      end
      write = 1'b1; write_data = DW'(i + 1); read = 1'b1;
      step();
    end
    idle();
    read = 1'b1;
    step();
    idle();
    checks++;
    if (empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL wrap_end: empty=%0b ov=%0b uf=%0b, required 1 0 0", empty, overflow, underflow);
    end
  endtask

  task automatic test_flush();
    err_clr = 1'b1;
    step();
    idle();
`ifdef FIFO_WATERMARK_EN
    checks++;
    if (max_level !== 3'd0) begin
      errors++;
      $display("FAIL max_clr: max_level=%0d required 0", max_level);
    end
`endif
    for (int i = 0; i < 3; i++) begin write = 1'b1; write_data = DW'(8'h60 + i); step(); end
    flush = 1'b1; write = 1'b1; read = 1'b1; write_data = 8'h99;
    step();
    idle();
    checks++;
    if (fill_level !== 3'd0 || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL flush: fill=%0d empty=%0b ov=%0b uf=%0b, required 0 1 0 0",
               fill_level, empty, overflow, underflow);
    end
`ifdef FIFO_WATERMARK_EN
    checks++;
    if (max_level !== 3'd3) begin
      errors++;
      $display("FAIL flush_max: max_level=%0d required 3", max_level);
    end
`endif
    // Flush on an empty FIFO with read must not raise underflow.
    flush = 1'b1; read = 1'b1;
    step();
    idle();
    checks++;
    if (underflow !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL flush_empty: uf=%0b empty=%0b, required 0 1", underflow, empty);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin write = 1'b1; write_data = DW'(8'hC0 + i); step(); end
    write = 1'b1; write_data = 8'h77;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (fill_level !== 3'd0 || empty !== 1'b1 || almost_empty !== 1'b1 || read_data !== 8'h00 || full !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: fill=%0d empty=%0b ae=%0b rdata=%02h full=%0b, required 0 1 1 00 0",
               fill_level, empty, almost_empty, read_data, full);
    end
    step();
    idle();
    rst = 1'b0;
    step();
    checks++;
    if (fill_level !== 3'd0 || read_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold: fill=%0d rdata=%02h, required 0 00", fill_level, read_data);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_underflow();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
